mdu_param: RTL

- Parametrised multiply/divide unit for the 5-stage pipeline; sits in E stage next to the ALU.
- Successor to the fixed 32-bit MDU: configurable data width and per-operation latencies.
- Adds multiply-accumulate ops, a completion pulse, and a defined cancel rule on exception request.
- Holds architectural HI/LO; the stall controller consumes busy.

---
 rtl/mdu_pkg.sv | 53 +++++
 rtl/mdu_div_core.sv | 41 ++++
 rtl/mdu_param.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: md_type codes and op classification helpers for the MDU
// and the stall unit. Macro MDU_MADD_EN enables the accumulate codes.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_type_e;

  // Codes that occupy the unit for several cycles.
  function automatic logic md_is_long(
    input logic [3:0] code
  );
    logic r;
    r = 1'b0;
    case (code)
      MD_MULT, MD_MULTU,
      MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU,
      MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Codes that read or write HI/LO directly.
  function automatic logic md_is_hilo(
    input logic [3:0] code
  );
    logic r;
    r = 1'b0;
    case (code)
      MD_MFHI, MD_MFLO,
      MD_MTHI, MD_MTLO: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: combinational WIDTH-bit signed/unsigned divider.
// Ports: sgn, a (dividend), b (divisor), hi/lo (current regs) -> q, r.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] mr;

  assign neg_a = sgn & a[WIDTH-1];
  assign neg_b = sgn & b[WIDTH-1];
  assign ma    = neg_a ? -a : a;
  assign mb    = neg_b ? -b : b;

  // Magnitude divide; most-negative / -1 falls out as
  // q = most-negative, r = 0 without a special case.
  assign mq = (mb == '0) ? '0 : ma / mb;
  assign mr = (mb == '0) ? '0 : ma % mb;

  always_comb begin
    q = lo;
    r = hi;
    if (b != '0) begin
      q = (neg_a ^ neg_b) ? -mq : mq;
      r = neg_a ? -mr : mr;
    end
  end

endmodule

// File: rtl/mdu_param.sv
// mdu_param: parametrised multiply/divide unit with HI/LO, busy, done.
// Ports: clk, reset, start, req, md_type, rs, rt -> busy, done, md_out.
// Macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mdu_param import mdu_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             req,
  input  logic [3:0]       md_type,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] md_out
);

  localparam int MAXC =
    (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   pend_hi;
  logic [WIDTH-1:0]   pend_lo;

  logic               accept;
  logic               long_go;
  logic               is_div;
  logic               sgn;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] long_res;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;
`ifdef MDU_MADD_EN
  logic               acc_add;
  logic               acc_sub;
`endif

  assign accept  = start && !req && (state == IDLE);
  assign long_go = accept && md_is_long(md_type);

  always_comb begin
    is_div = 1'b0;
    sgn    = 1'b0;
`ifdef MDU_MADD_EN
    acc_add = 1'b0;
    acc_sub = 1'b0;
`endif
    case (md_type)
      MD_MULT: sgn = 1'b1;
      MD_DIV: begin
        is_div = 1'b1;
        sgn    = 1'b1;
      end
      MD_DIVU: is_div = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD: begin
        sgn     = 1'b1;
        acc_add = 1'b1;
      end
      MD_MADDU: acc_add = 1'b1;
      MD_MSUB: begin
        sgn     = 1'b1;
        acc_sub = 1'b1;
      end
      MD_MSUBU: acc_sub = 1'b1;
`endif
      default: ;
    endcase
  end

  // Extending to 2W before an unsigned multiply gives the correct
  // low 2W bits for both signed and unsigned products.
  assign ext_a = sgn ? {{WIDTH{rs[WIDTH-1]}}, rs}
                     : {{WIDTH{1'b0}}, rs};
  assign ext_b = sgn ? {{WIDTH{rt[WIDTH-1]}}, rt}
                     : {{WIDTH{1'b0}}, rt};
  assign prod  = ext_a * ext_b;

  mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .sgn(sgn),
    .a  (rs),
    .b  (rt),
    .hi (hi),
    .lo (lo),
    .q  (div_q),
    .r  (div_r)
  );

  always_comb begin
    long_res = prod;
`ifdef MDU_MADD_EN
    if (acc_add)
      long_res = {hi, lo} + prod;
    else if (acc_sub)
      long_res = {hi, lo} - prod;
`endif
    if (is_div)
      long_res = {div_r, div_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (long_go) begin
            {pend_hi, pend_lo} <= long_res;
            cnt   <= is_div ? CW'(DIV_CYCLES)
                            : CW'(MUL_CYCLES);
            busy  <= 1'b1;
            state <= BUSY;
          end else if (accept) begin
            if (md_type == MD_MTHI)
              hi <= rs;
            else if (md_type == MD_MTLO)
              lo <= rs;
          end
        end
        BUSY: begin
          // req is ignored here: the op in flight is committed.
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign md_out = (md_type == MD_MFHI) ? hi :
                  (md_type == MD_MFLO) ? lo : '0;

  a_no_start_busy: assert property (
    @(posedge clk) disable iff (reset)
    !(start && state == BUSY)
  );

endmodule
